athos_xif_dispatch: RTL and testbench

Multi-lane eXtension-interface (XIF) front end for ATHOS accelerators. It sits between the cv32e40x XIF ports and NUM_LANES accelerator lanes. It accepts custom-0 instructions, holds them until the core commits or kills them, and dispatches committed instructions in issue order to the selected lane. It then arbitrates the lanes' results back onto a single XIF result channel.

---
 rtl/athos_xif_dispatch_if.sv | 58 +++++
 rtl/athos_xif_dispatch.sv | 219 +++++++++++++++++++++
 tb/tb_athos_xif_dispatch.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/athos_xif_dispatch_if.sv
// Signal bundle between the XIF core ports, the accelerator lanes and athos_xif_dispatch.
// slave = dispatcher view, master = core/lane environment view.
interface athos_xif_dispatch_if #(
  parameter int NUM_LANES = 2,
  parameter int ID_WIDTH  = 4,
  parameter int XLEN      = 32
);
  logic                      issue_valid_i;
  logic                      issue_ready_o;
  logic [31:0]               issue_instr_i;
  logic [ID_WIDTH-1:0]       issue_id_i;
  logic [XLEN-1:0]           issue_rs1_i;
  logic [XLEN-1:0]           issue_rs2_i;
  logic                      issue_accept_o;
  logic                      issue_writeback_o;
  logic                      commit_valid_i;
  logic [ID_WIDTH-1:0]       commit_id_i;
  logic                      commit_kill_i;
  logic [NUM_LANES-1:0]      lane_valid_o;
  logic [NUM_LANES-1:0]      lane_ready_i;
  logic [31:0]               lane_instr_o;
  logic [ID_WIDTH-1:0]       lane_id_o;
  logic [XLEN-1:0]           lane_rs1_o;
  logic [XLEN-1:0]           lane_rs2_o;
  logic [NUM_LANES-1:0]      lane_res_valid_i;
  logic [NUM_LANES-1:0]      lane_res_ready_o;
  logic [NUM_LANES*ID_WIDTH-1:0] lane_res_id_i;
  logic [NUM_LANES*XLEN-1:0] lane_res_data_i;
  logic [NUM_LANES*5-1:0]    lane_res_rd_i;
  logic                      result_valid_o;
  logic                      result_ready_i;
  logic [ID_WIDTH-1:0]       result_id_o;
  logic [XLEN-1:0]           result_data_o;
  logic [4:0]                result_rd_o;
  logic                      result_we_o;

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
    input  commit_valid_i, commit_id_i, commit_kill_i,
    input  lane_ready_i, lane_res_valid_i, lane_res_id_i, lane_res_data_i, lane_res_rd_i,
    input  result_ready_i,
    output issue_ready_o, issue_accept_o, issue_writeback_o,
    output lane_valid_o, lane_instr_o, lane_id_o, lane_rs1_o, lane_rs2_o,
    output lane_res_ready_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
    output commit_valid_i, commit_id_i, commit_kill_i,
    output lane_ready_i, lane_res_valid_i, lane_res_id_i, lane_res_data_i, lane_res_rd_i,
    output result_ready_i,
    input  issue_ready_o, issue_accept_o, issue_writeback_o,
    input  lane_valid_o, lane_instr_o, lane_id_o, lane_rs1_o, lane_rs2_o,
    input  lane_res_ready_o,
    input  result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/athos_xif_dispatch.sv
// XIF front end: buffers custom-0 instructions until commit/kill, dispatches in issue order to lanes,
// arbitrates lane results onto one result channel. ATHOS_XIF_INORDER_RESULT_EN forces dispatch-order results.
module athos_xif_dispatch #(
  parameter int NUM_LANES = 2,
  parameter int DEPTH     = 4,
  parameter int ID_WIDTH  = 4,
  parameter int XLEN      = 32
) (
  input logic            clk_i,
  input logic            rst_ni,
  athos_xif_dispatch_if.slave xif
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [6:0] OPC_CUSTOM0 = 7'h0B;
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [ID_WIDTH-1:0] r_id    [DEPTH];
  logic [31:0]         r_instr [DEPTH];
  logic [XLEN-1:0]     r_rs1   [DEPTH];
  logic [XLEN-1:0]     r_rs2   [DEPTH];
  logic [LANE_W-1:0]   r_lane  [DEPTH];
  logic [DEPTH-1:0]    r_valid;
  logic [DEPTH-1:0]    r_committed;
  logic [DEPTH-1:0]    r_killed;
  logic [PTR_W-1:0]    r_head;
  logic [PTR_W-1:0]    r_tail;
  logic [PTR_W:0]      r_count;

  logic                r_out_valid;
  logic [ID_WIDTH-1:0] r_out_id;
  logic [XLEN-1:0]     r_out_data;
  logic [4:0]          r_out_rd;
  logic                r_out_we;
  logic [LANE_W-1:0]   r_rr_ptr;

  logic [LANE_W-1:0]    w_dec_lane;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue_cmt;
  logic                 w_issue_kill;
  logic [LANE_W-1:0]    w_head_lane;
  logic                 w_head_kill;
  logic                 w_head_cmt;
  logic                 w_disp_ok;
  logic                 w_disp_req;
  logic                 w_disp_fire;
  logic [NUM_LANES-1:0] w_res_req;
  logic                 w_hi_found;
  logic                 w_lo_found;
  logic [LANE_W-1:0]    w_hi_lane;
  logic [LANE_W-1:0]    w_lo_lane;
  logic [LANE_W-1:0]    w_gnt_lane;
  logic                 w_out_free;
  logic                 w_res_fire;
  logic [4:0]           w_gnt_rd;

  // Decode
  assign w_dec_lane = xif.issue_instr_i[25 +: LANE_W];
  assign w_accept   = (xif.issue_instr_i[6:0] == OPC_CUSTOM0) && (int'(w_dec_lane) < NUM_LANES);
  assign xif.issue_accept_o    = w_accept;
  assign xif.issue_writeback_o = w_accept && (xif.issue_instr_i[11:7] != 5'd0);
  assign xif.issue_ready_o     = (r_count != CNT_FULL);

  assign w_push       = xif.issue_valid_i & xif.issue_ready_o & w_accept;
  assign w_issue_cmt  = xif.commit_valid_i & (xif.commit_id_i == xif.issue_id_i) & ~xif.commit_kill_i;
  assign w_issue_kill = xif.commit_valid_i & (xif.commit_id_i == xif.issue_id_i) & xif.commit_kill_i;

  assign w_head_lane = r_lane[r_head];
  assign w_head_kill = r_valid[r_head] & r_killed[r_head];
  assign w_head_cmt  = r_valid[r_head] & r_committed[r_head] & ~r_killed[r_head];
  assign w_disp_req  = w_head_cmt & w_disp_ok;
  assign w_disp_fire = w_disp_req & xif.lane_ready_i[w_head_lane];
  assign w_pop       = w_head_kill | w_disp_fire;

  assign xif.lane_valid_o = w_disp_req ? (NUM_LANES'(1) << w_head_lane) : '0;
  assign xif.lane_instr_o = r_instr[r_head];
  assign xif.lane_id_o    = r_id[r_head];
  assign xif.lane_rs1_o   = r_rs1[r_head];
  assign xif.lane_rs2_o   = r_rs2[r_head];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_id[i]    <= '0;
        r_instr[i] <= '0;
        r_rs1[i]   <= '0;
        r_rs2[i]   <= '0;
        r_lane[i]  <= '0;
      end
      r_valid     <= '0;
      r_committed <= '0;
      r_killed    <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      if (xif.commit_valid_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_valid[i] && (r_id[i] == xif.commit_id_i)) begin
            if (xif.commit_kill_i) r_killed[i] <= 1'b1;
            else                   r_committed[i] <= 1'b1;
          end
        end
      end
      // Pop clears after the commit scan so a late commit cannot resurrect a freed slot.
      if (w_pop) begin
        r_valid[r_head]     <= 1'b0;
        r_committed[r_head] <= 1'b0;
        r_killed[r_head]    <= 1'b0;
        r_head              <= r_head + 1'b1;
      end
      if (w_push) begin
        r_valid[r_tail]     <= 1'b1;
        r_committed[r_tail] <= w_issue_cmt;
        r_killed[r_tail]    <= w_issue_kill;
        r_id[r_tail]        <= xif.issue_id_i;
        r_instr[r_tail]     <= xif.issue_instr_i;
        r_rs1[r_tail]       <= xif.issue_rs1_i;
        r_rs2[r_tail]       <= xif.issue_rs2_i;
        r_lane[r_tail]      <= w_dec_lane;
        r_tail              <= r_tail + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ATHOS_XIF_INORDER_RESULT_EN
  logic [LANE_W-1:0] r_ord_lane [DEPTH];
  logic [PTR_W-1:0]  r_ord_head;
  logic [PTR_W-1:0]  r_ord_tail;
  logic [PTR_W:0]    r_ord_count;

  // Dispatch holds off while the order FIFO is full so no lane order is ever lost.
  assign w_disp_ok = (r_ord_count != CNT_FULL);
  assign w_res_req = (r_ord_count != '0) ?
                     (xif.lane_res_valid_i & (NUM_LANES'(1) << r_ord_lane[r_ord_head])) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) r_ord_lane[i] <= '0;
      r_ord_head  <= '0;
      r_ord_tail  <= '0;
      r_ord_count <= '0;
    end else begin
      if (w_disp_fire) begin
        r_ord_lane[r_ord_tail] <= w_head_lane;
        r_ord_tail             <= r_ord_tail + 1'b1;
      end
      if (w_res_fire) r_ord_head <= r_ord_head + 1'b1;
      unique case ({w_disp_fire, w_res_fire})
        2'b10:   r_ord_count <= r_ord_count + 1'b1;
        2'b01:   r_ord_count <= r_ord_count - 1'b1;
        default: r_ord_count <= r_ord_count;
      endcase
    end
  end
`else
  assign w_disp_ok = 1'b1;
  assign w_res_req = xif.lane_res_valid_i;
`endif

  // Round robin: lowest requester at or above the pointer, else lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_lane  = '0;
    w_lo_found = 1'b0;
    w_lo_lane  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_res_req[i]) begin
        w_lo_found = 1'b1;
        w_lo_lane  = LANE_W'(i);
        if (i >= int'(r_rr_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_lane  = LANE_W'(i);
        end
      end
    end
  end

  assign w_gnt_lane = w_hi_found ? w_hi_lane : w_lo_lane;
  assign w_out_free = ~r_out_valid | xif.result_ready_i;
  assign w_res_fire = w_lo_found & w_out_free;
  assign w_gnt_rd   = xif.lane_res_rd_i[int'(w_gnt_lane)*5 +: 5];
  assign xif.lane_res_ready_o = w_res_fire ? (NUM_LANES'(1) << w_gnt_lane) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_data  <= '0;
      r_out_rd    <= '0;
      r_out_we    <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_res_fire) begin
        r_out_valid <= 1'b1;
        r_out_id    <= xif.lane_res_id_i[int'(w_gnt_lane)*ID_WIDTH +: ID_WIDTH];
        r_out_data  <= xif.lane_res_data_i[int'(w_gnt_lane)*XLEN +: XLEN];
        r_out_rd    <= w_gnt_rd;
        r_out_we    <= (w_gnt_rd != 5'd0);
        r_rr_ptr    <= (w_gnt_lane == LANE_W'(NUM_LANES - 1)) ? '0 : w_gnt_lane + 1'b1;
      end else if (r_out_valid && xif.result_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign xif.result_valid_o = r_out_valid;
  assign xif.result_id_o    = r_out_id;
  assign xif.result_data_o  = r_out_data;
  assign xif.result_rd_o    = r_out_rd;
  assign xif.result_we_o    = r_out_we;
endmodule

// File: tb/tb_athos_xif_dispatch.sv
// Directed bench for athos_xif_dispatch: dispatch and result scoreboards plus a 3-lane decode instance.
// Result-order expectations follow ATHOS_XIF_INORDER_RESULT_EN when it is defined.
module tb_athos_xif_dispatch;
  localparam int NL   = 2;
  localparam int DEP  = 4;
  localparam int IDW  = 4;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            we;
  } res_t;

  typedef struct packed {
    logic [NL-1:0]  lane;
    logic [IDW-1:0] id;
  } disp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t  res_q[$];
  disp_t disp_q[$];

  athos_xif_dispatch_if #(.NUM_LANES(NL), .ID_WIDTH(IDW), .XLEN(XLEN)) xif ();
  athos_xif_dispatch_if #(.NUM_LANES(3), .ID_WIDTH(IDW), .XLEN(XLEN)) xif3 ();

  athos_xif_dispatch #(.NUM_LANES(NL), .DEPTH(DEP), .ID_WIDTH(IDW), .XLEN(XLEN)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .xif   (xif)
  );

  athos_xif_dispatch #(.NUM_LANES(3), .DEPTH(DEP), .ID_WIDTH(IDW), .XLEN(XLEN)) u_dut3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .xif   (xif3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input int lane, input logic [4:0] rd, input logic [6:0] opc);
    logic [31:0] v;
    v        = '0;
    v[6:0]   = opc;
    v[11:7]  = rd;
    v[26:25] = 2'(lane);
    return v;
  endfunction

  function automatic res_t mkres(input logic [IDW-1:0] id, input logic [XLEN-1:0] d, input logic [4:0] rd);
    res_t r;
    r.id   = id;
    r.data = d;
    r.rd   = rd;
    r.we   = (rd != 5'd0);
    return r;
  endfunction

  task automatic issue(input logic [IDW-1:0] id, input logic [31:0] instr,
                       input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2);
    xif.issue_valid_i = 1'b1;
    xif.issue_id_i    = id;
    xif.issue_instr_i = instr;
    xif.issue_rs1_i   = rs1;
    xif.issue_rs2_i   = rs2;
  endtask

  task automatic idle_issue();
    xif.issue_valid_i = 1'b0;
    xif.issue_instr_i = '0;
  endtask

  task automatic commit(input logic v, input logic [IDW-1:0] id, input logic kill);
    xif.commit_valid_i = v;
    xif.commit_id_i    = id;
    xif.commit_kill_i  = kill;
  endtask

  task automatic check_dispatch();
    disp_t e;
    chk("disp_sb_nonempty", 64'(disp_q.size() == 0), 64'(0));
    if (disp_q.size() != 0) begin
      e = disp_q.pop_front();
      chk("disp_lane", 64'(xif.lane_valid_o), 64'(e.lane));
      chk("disp_id", 64'(xif.lane_id_o), 64'(e.id));
    end
  endtask

  task automatic check_result();
    res_t e;
    res_t o;
    o.id   = xif.result_id_o;
    o.data = xif.result_data_o;
    o.rd   = xif.result_rd_o;
    o.we   = xif.result_we_o;
    chk("res_valid", 64'(xif.result_valid_o), 64'(1));
    chk("res_sb_nonempty", 64'(res_q.size() == 0), 64'(0));
    if (res_q.size() != 0) begin
      e = res_q.pop_front();
      chk("res_fields", 64'(o), 64'(e));
    end
  endtask

  initial begin
    logic [31:0]   instr_exp;
    logic [NL-1:0] g;

    rst_n = 1'b0;
    xif.issue_valid_i = 0;  xif.issue_instr_i = '0; xif.issue_id_i = '0;
    xif.issue_rs1_i = '0;   xif.issue_rs2_i = '0;
    xif.commit_valid_i = 0; xif.commit_id_i = '0;   xif.commit_kill_i = 0;
    xif.lane_ready_i = '0;  xif.lane_res_valid_i = '0; xif.lane_res_id_i = '0;
    xif.lane_res_data_i = '0; xif.lane_res_rd_i = '0; xif.result_ready_i = 0;
    xif3.issue_valid_i = 0; xif3.issue_instr_i = '0; xif3.issue_id_i = '0;
    xif3.issue_rs1_i = '0;  xif3.issue_rs2_i = '0;
    xif3.commit_valid_i = 0; xif3.commit_id_i = '0; xif3.commit_kill_i = 0;
    xif3.lane_ready_i = '0; xif3.lane_res_valid_i = '0; xif3.lane_res_id_i = '0;
    xif3.lane_res_data_i = '0; xif3.lane_res_rd_i = '0; xif3.result_ready_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_issue_ready", 64'(xif.issue_ready_o), 64'(1));
    chk("rst_lane_valid", 64'(xif.lane_valid_o), 64'(0));
    chk("rst_result_valid", 64'(xif.result_valid_o), 64'(0));
    chk("rst_res_ready", 64'(xif.lane_res_ready_o), 64'(0));
    chk("rst_accept", 64'(xif.issue_accept_o), 64'(0));
    chk("rst_lane_rs1", 64'(xif.lane_rs1_o), 64'(0));
    rst_n = 1'b1;

    // Basic dispatch
    tick();
    instr_exp = mk(1, 5'd5, 7'h0B);
    issue(4'd3, instr_exp, 32'h11, 32'h22);
    #1;
    chk("basic_accept", 64'(xif.issue_accept_o), 64'(1));
    chk("basic_wb", 64'(xif.issue_writeback_o), 64'(1));
    tick();
    idle_issue();
    commit(1, 4'd3, 0);
    #1;
    chk("basic_no_early_disp", 64'(xif.lane_valid_o), 64'(0));
    tick();
    commit(0, 4'd0, 0);
    disp_q.push_back('{lane: 2'b10, id: 4'd3});
    #1;
    check_dispatch();
    chk("basic_rs1", 64'(xif.lane_rs1_o), 64'h11);
    chk("basic_rs2", 64'(xif.lane_rs2_o), 64'h22);
    chk("basic_instr", 64'(xif.lane_instr_o), 64'(instr_exp));
    xif.lane_ready_i = 2'b10;
    tick();
    xif.lane_ready_i = 2'b00;
    #1;
    chk("basic_popped", 64'(xif.lane_valid_o), 64'(0));
    xif.lane_res_valid_i = 2'b10;
    xif.lane_res_id_i[7:4] = 4'd3;
    xif.lane_res_data_i[63:32] = 32'hCAFE;
    xif.lane_res_rd_i[9:5] = 5'd5;
    res_q.push_back(mkres(4'd3, 32'hCAFE, 5'd5));
    #1;
    chk("basic_grant", 64'(xif.lane_res_ready_o), 64'(2'b10));
    chk("basic_res_not_yet", 64'(xif.result_valid_o), 64'(0));
    tick();
    xif.lane_res_valid_i = 2'b00;
    #1;
    check_result();
    xif.result_ready_i = 1'b1;
    tick();
    xif.result_ready_i = 1'b0;
    #1;
    chk("basic_res_cleared", 64'(xif.result_valid_o), 64'(0));

    // Reject, then same-cycle issue+commit
    tick();
    issue(4'd6, mk(0, 5'd1, 7'h33), 32'h6, 32'h6);
    xif3.issue_instr_i = mk(3, 5'd1, 7'h0B);
    #1;
    chk("reject_opc_accept", 64'(xif.issue_accept_o), 64'(0));
    chk("reject_opc_wb", 64'(xif.issue_writeback_o), 64'(0));
    chk("reject_lane3_accept", 64'(xif3.issue_accept_o), 64'(0));
    tick();
    issue(4'd7, mk(0, 5'd0, 7'h0B), 32'h70, 32'h71);
    commit(1, 4'd7, 0);
    xif3.issue_instr_i = mk(2, 5'd1, 7'h0B);
    #1;
    chk("lane2_of3_accept", 64'(xif3.issue_accept_o), 64'(1));
    chk("rd0_wb", 64'(xif.issue_writeback_o), 64'(0));
    tick();
    idle_issue();
    commit(0, 4'd0, 0);
    disp_q.push_back('{lane: 2'b01, id: 4'd7});
    #1;
    check_dispatch();
    chk("same_cycle_rs1", 64'(xif.lane_rs1_o), 64'h70);
    xif.lane_ready_i = 2'b01;
    tick();
    xif.lane_ready_i = 2'b00;
    #1;
    chk("same_cycle_popped", 64'(xif.lane_valid_o), 64'(0));
    xif.lane_res_valid_i = 2'b01;
    xif.lane_res_id_i[3:0] = 4'd7;
    xif.lane_res_data_i[31:0] = 32'h77;
    xif.lane_res_rd_i[4:0] = 5'd0;
    xif.result_ready_i = 1'b1;
    res_q.push_back(mkres(4'd7, 32'h77, 5'd0));
    tick();
    xif.lane_res_valid_i = 2'b00;
    #1;
    check_result();
    tick();
    xif.result_ready_i = 1'b0;
    #1;
    chk("rd0_res_cleared", 64'(xif.result_valid_o), 64'(0));

    // Kill at head
    tick();
    issue(4'd1, mk(0, 5'd2, 7'h0B), 32'h1, 32'h1);
    tick();
    issue(4'd2, mk(1, 5'd3, 7'h0B), 32'h2, 32'h2);
    commit(1, 4'd1, 1);
    #1;
    chk("kill_no_disp_a", 64'(xif.lane_valid_o), 64'(0));
    tick();
    idle_issue();
    commit(1, 4'd2, 0);
    #1;
    chk("kill_head_no_disp", 64'(xif.lane_valid_o), 64'(0));
    tick();
    commit(0, 4'd0, 0);
    disp_q.push_back('{lane: 2'b10, id: 4'd2});
    #1;
    check_dispatch();
    xif.lane_ready_i = 2'b10;
    tick();
    xif.lane_ready_i = 2'b00;
    #1;
    chk("kill_popped", 64'(xif.lane_valid_o), 64'(0));
    xif.lane_res_valid_i = 2'b10;
    xif.lane_res_id_i[7:4] = 4'd2;
    xif.lane_res_data_i[63:32] = 32'h222;
    xif.lane_res_rd_i[9:5] = 5'd3;
    xif.result_ready_i = 1'b1;
    res_q.push_back(mkres(4'd2, 32'h222, 5'd3));
    tick();
    xif.lane_res_valid_i = 2'b00;
    #1;
    check_result();
    tick();
    xif.result_ready_i = 1'b0;

    // Full buffer
    for (int k = 0; k < 4; k++) begin
      tick();
      issue(4'(8 + k), mk(k % 2, 5'd1, 7'h0B), 32'(k), 32'(k));
      #1;
      chk("fill_ready", 64'(xif.issue_ready_o), 64'(1));
    end
    tick();
    issue(4'd12, mk(0, 5'd1, 7'h0B), 32'hC, 32'hC);
    commit(1, 4'd8, 0);
    #1;
    chk("full_ready", 64'(xif.issue_ready_o), 64'(0));
    chk("full_no_disp", 64'(xif.lane_valid_o), 64'(0));
    tick();
    commit(0, 4'd0, 0);
    disp_q.push_back('{lane: 2'b01, id: 4'd8});
    #1;
    check_dispatch();
    chk("full_pop_cycle_ready", 64'(xif.issue_ready_o), 64'(0));
    xif.lane_ready_i = 2'b01;
    tick();
    xif.lane_ready_i = 2'b00;
    #1;
    chk("full_reopen", 64'(xif.issue_ready_o), 64'(1));
    chk("full_head_stall", 64'(xif.lane_valid_o), 64'(0));
    tick();
    idle_issue();
    #1;
    chk("full_refilled", 64'(xif.issue_ready_o), 64'(0));
    disp_q.push_back('{lane: 2'b10, id: 4'd9});
    disp_q.push_back('{lane: 2'b01, id: 4'd10});
    for (int c = 0; c < 6; c++) begin
      tick();
      commit(c < 2, (c == 0) ? 4'd10 : 4'd9, 0);
      xif.lane_ready_i = 2'b11;
      #1;
      if (xif.lane_valid_o != '0) check_dispatch();
    end
    chk("disp_sb_drained", 64'(disp_q.size()), 64'(0));

    // Reset mid-operation with a result held in the output register
    tick();
    commit(0, 4'd0, 0);
    xif.lane_ready_i = 2'b00;
    xif.lane_res_valid_i = 2'b01;
    xif.lane_res_id_i[3:0] = 4'd8;
    xif.lane_res_data_i[31:0] = 32'h88;
    tick();
    xif.lane_res_valid_i = 2'b00;
    #1;
    chk("pre_reset_result", 64'(xif.result_valid_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_result", 64'(xif.result_valid_o), 64'(0));
    chk("async_rst_ready", 64'(xif.issue_ready_o), 64'(1));
    tick();
    tick();
    rst_n = 1'b1;
    commit(1, 4'd11, 0);
    tick();
    commit(0, 4'd0, 0);
    #1;
    chk("rst_discards_buf", 64'(xif.lane_valid_o), 64'(0));

    // Result contention: dispatch lane 1 (id 4) then lane 0 (id 5)
    tick();
    issue(4'd4, mk(1, 5'd4, 7'h0B), 32'h4, 32'h4);
    commit(1, 4'd4, 0);
    xif.lane_ready_i = 2'b11;
    tick();
    issue(4'd5, mk(0, 5'd3, 7'h0B), 32'h5, 32'h5);
    commit(1, 4'd5, 0);
    disp_q.push_back('{lane: 2'b10, id: 4'd4});
    #1;
    check_dispatch();
    tick();
    idle_issue();
    commit(0, 4'd0, 0);
    disp_q.push_back('{lane: 2'b01, id: 4'd5});
    #1;
    check_dispatch();
    tick();
    xif.lane_ready_i = 2'b00;
    xif.lane_res_valid_i = 2'b11;
    xif.lane_res_id_i = {4'd4, 4'd5};
    xif.lane_res_data_i = {32'h44, 32'h55};
    xif.lane_res_rd_i = {5'd4, 5'd3};
`ifdef ATHOS_XIF_INORDER_RESULT_EN
    res_q.push_back(mkres(4'd4, 32'h44, 5'd4));
    res_q.push_back(mkres(4'd5, 32'h55, 5'd3));
`else
    res_q.push_back(mkres(4'd5, 32'h55, 5'd3));
    res_q.push_back(mkres(4'd4, 32'h44, 5'd4));
`endif
    for (int c = 0; c < 10; c++) begin
      xif.result_ready_i = (c >= 3);
      #1;
      g = xif.lane_res_ready_o;
      if (c == 1) chk("grant_blocked_when_full", 64'(g), 64'(0));
      if (xif.result_valid_o && xif.result_ready_i) check_result();
      tick();
      xif.lane_res_valid_i = xif.lane_res_valid_i & ~g;
    end
    chk("res_sb_drained", 64'(res_q.size()), 64'(0));
    chk("res_final_idle", 64'(xif.result_valid_o), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
